main_fsm: RTL

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm_pkg.sv | 69 ++++++
 rtl/main_fsm_outdec.sv | 110 +++++++++++
 rtl/main_fsm.sv | 108 ++++++++++
 3 files changed

// File: rtl/main_fsm_pkg.sv
// Shared types for the multicycle RISC-V main control FSM: state encoding,
// opcode constants, datapath select encodings and the supported-opcode check.
// Optional feature: define MAIN_FSM_JALR_EN to add the JALR/JALRLINK states.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef MAIN_FSM_JALR_EN
    ,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // True when DECODE has somewhere to go for this opcode; everything else
  // is flagged illegal and sent back to FETCH.
  function automatic logic op_supported(input logic [6:0] op);
    logic ok;
    ok = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
         (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
`ifdef MAIN_FSM_JALR_EN
    ok = ok || (op == OP_JALR);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational per-state output decode for main_fsm. Strobes here are raw;
// the top gates them with reset.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_t      state,
  input  logic [6:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        reg_write,
  output alu_src_a_t  alu_src_a,
  output alu_src_b_t  alu_src_b,
  output result_src_t result_src,
  output alu_op_t     alu_op,
  output logic        illegal_op
);

  logic pc_update;
  logic branch;

  // Drive each state's controls; anything a state does not mention stays 0.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        illegal_op = ~op_supported(op);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
`ifdef MAIN_FSM_JALR_EN
      S_JALR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      S_JALRLINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        reg_write  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // A taken branch writes the PC in the same cycle the ALU reports zero.
  assign pc_write = pc_update | (branch & zero);

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: state register and next-state logic,
// with output decode in main_fsm_outdec. Strobes are held low while reset=0.
// Optional feature: MAIN_FSM_JALR_EN adds the JALR -> JALRLINK sequence.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  state_t      state_q;
  state_t      state_d;
  logic        dec_pc_write;
  logic        dec_ir_write;
  logic        dec_mem_write;
  logic        dec_reg_write;
  logic        dec_illegal_op;
  alu_src_a_t  dec_alu_src_a;
  alu_src_b_t  dec_alu_src_b;
  result_src_t dec_result_src;
  alu_op_t     dec_alu_op;

  // State register; reset=0 drops straight back to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its pre-edge value regardless of statement order.
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; unknown encodings fall through to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef MAIN_FSM_JALR_EN
          OP_JALR:           state_d = S_JALR;
`endif
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef MAIN_FSM_JALR_EN
      S_JALR:     state_d = S_JALRLINK;
      S_JALRLINK: state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state      (state_q),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (dec_pc_write),
    .ir_write   (dec_ir_write),
    .adr_src    (adr_src),
    .mem_write  (dec_mem_write),
    .reg_write  (dec_reg_write),
    .alu_src_a  (dec_alu_src_a),
    .alu_src_b  (dec_alu_src_b),
    .result_src (dec_result_src),
    .alu_op     (dec_alu_op),
    .illegal_op (dec_illegal_op)
  );

  // Selects already show FETCH values during reset because the state is
  // forced there; strobes are gated so nothing writes while reset is low.
  assign pc_write   = reset & dec_pc_write;
  assign ir_write   = reset & dec_ir_write;
  assign mem_write  = reset & dec_mem_write;
  assign reg_write  = reset & dec_reg_write;
  assign illegal_op = reset & dec_illegal_op;
  assign alu_src_a  = dec_alu_src_a;
  assign alu_src_b  = dec_alu_src_b;
  assign result_src = dec_result_src;
  assign alu_op     = dec_alu_op;

endmodule
